// File: rtl/alu_sequencer.sv
// Register-file sequencer that drives an external 4-bit ALU.
// It accepts one command at a time and returns one response per command.
module alu_sequencer #(
    parameter int RES_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [1:0] cmd_ra,
    input  logic [1:0] cmd_rb,
    input  logic [1:0] cmd_rd,
    input  logic       cmd_ld,
    input  logic [3:0] cmd_imm,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic [3:0] alu_res,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic [1:0] rsp_rd,
    output logic       rsp_err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_e;

    localparam logic [2:0] LAST = 3'(RES_LAT - 1);

    state_e     state_q, state_d;
    logic [3:0] regs_q [4];
    logic [3:0] regs_d [4];
    logic [1:0] rd_q, rd_d;
    logic       ld_q, ld_d;
    logic       err_q, err_d;
    logic [3:0] imm_q, imm_d;
    logic [3:0] res_q, res_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [3:0] alu_sel_q, alu_sel_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [3:0] rsp_data_q, rsp_data_d;
    logic [1:0] rsp_rd_q, rsp_rd_d;
    logic       rsp_err_q, rsp_err_d;
    logic       cmd_bad;

    assign cmd_bad = !cmd_ld && (cmd_op > 4'd12);

    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        rd_d        = rd_q;
        ld_d        = ld_q;
        err_d       = err_q;
        imm_d       = imm_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_rd_d    = rsp_rd_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    rd_d  = cmd_rd;
                    ld_d  = cmd_ld;
                    imm_d = cmd_imm;
                    err_d = cmd_bad;
                    cnt_d = 3'd0;
                    if (cmd_ld || cmd_bad) begin
                        state_d = CAPTURE;
                    end else begin
                        alu_a_d   = regs_q[cmd_ra];
                        alu_b_d   = regs_q[cmd_rb];
                        alu_sel_d = cmd_op;
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (cnt_q == LAST) begin
                    res_d   = alu_res;
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            CAPTURE: begin
                rsp_valid_d = 1'b1;
                rsp_rd_d    = rd_q;
                rsp_err_d   = err_q;
                if (err_q) begin
                    rsp_data_d = 4'd0;
                end else if (ld_q) begin
                    rsp_data_d   = imm_q;
                    regs_d[rd_q] = imm_q;
                end else begin
                    rsp_data_d   = res_q;
                    regs_d[rd_q] = res_q;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= 4'd0;
            end
            rd_q        <= 2'd0;
            ld_q        <= 1'b0;
            err_q       <= 1'b0;
            imm_q       <= 4'd0;
            res_q       <= 4'd0;
            cnt_q       <= 3'd0;
            alu_a_q     <= 4'd0;
            alu_b_q     <= 4'd0;
            alu_sel_q   <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 4'd0;
            rsp_rd_q    <= 2'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            rd_q        <= rd_d;
            ld_q        <= ld_d;
            err_q       <= err_d;
            imm_q       <= imm_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_rd    = rsp_rd_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: slow ALU model, command driver,
// response scoreboard and randomized plus directed traffic.
module tb_alu_sequencer;

    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [1:0] cmd_ra;
    logic [1:0] cmd_rb;
    logic [1:0] cmd_rd;
    logic       cmd_ld;
    logic [3:0] cmd_imm;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_sel;
    logic [3:0] alu_res;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic [1:0] rsp_rd;
    logic       rsp_err;

    alu_sequencer #(.RES_LAT(LAT)) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_ra(cmd_ra),
        .cmd_rb(cmd_rb),
        .cmd_rd(cmd_rd),
        .cmd_ld(cmd_ld),
        .cmd_imm(cmd_imm),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_sel(alu_sel),
        .alu_res(alu_res),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_rd(rsp_rd),
        .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_f(input logic [3:0] a,
                                         input logic [3:0] b,
                                         input logic [3:0] sel);
        case (sel)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a ^ b;
            4'd3:    return ~a;
            4'd4:    return a;
            4'd5:    return b;
            4'd6:    return a << 1;
            4'd7:    return a >> 1;
            4'd8:    return a - 4'd1;
            4'd9:    return a + 4'd1;
            4'd10:   return a - b;
            4'd11:   return a + b;
            4'd12:   return b - a;
            default: return a;
        endcase
    endfunction

    // Slow ALU: the result is only correct once its inputs have been
    // stable long enough; before that it presents the complement.
    logic [11:0] last_in = 12'd0;
    int          age = 0;

    always @(posedge clk) begin
        if ({alu_a, alu_b, alu_sel} != last_in) begin
            last_in <= {alu_a, alu_b, alu_sel};
            age     <= 1;
        end else if (age < 100) begin
            age <= age + 1;
        end
    end

    always_comb begin
        alu_res = ~alu_f(alu_a, alu_b, alu_sel);
        if (({alu_a, alu_b, alu_sel} == last_in && age >= LAT - 1) || LAT == 1)
            alu_res = alu_f(alu_a, alu_b, alu_sel);
    end

    typedef struct packed {
        logic [3:0] data;
        logic [1:0] rd;
        logic       err;
    } rsp_t;

    rsp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    logic       hold_ready = 1'b0;
    logic [3:0] mregs[4];
    logic [3:0] m_a, m_b, m_sel;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mregs[i] = 4'd0;
        m_a = 4'd0;
        m_b = 4'd0;
        m_sel = 4'd0;
    endtask

    // Consumer: random backpressure, updated just after each rising edge.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares each accepted response with the scoreboard head.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_spurious", rsp_valid, 0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_rd", rsp_rd, e.rd);
                check("rsp_err", rsp_err, e.err);
            end
        end
    end

    task automatic send(input logic ld, input logic [3:0] op,
                        input logic [1:0] ra, input logic [1:0] rb,
                        input logic [1:0] rd, input logic [3:0] imm);
        int   n;
        logic alu_cmd;
        rsp_t e;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_timeout", cmd_ready, 1);
            return;
        end
        cmd_ld = ld;
        cmd_op = op;
        cmd_ra = ra;
        cmd_rb = rb;
        cmd_rd = rd;
        cmd_imm = imm;
        cmd_valid = 1'b1;
        alu_cmd = !ld && (op <= 4'd12);
        e.rd = rd;
        e.err = 1'b0;
        if (ld) begin
            e.data = imm;
            mregs[rd] = imm;
        end else if (!alu_cmd) begin
            e.data = 4'd0;
            e.err = 1'b1;
        end else begin
            m_a = mregs[ra];
            m_b = mregs[rb];
            m_sel = op;
            e.data = alu_f(m_a, m_b, op);
            mregs[rd] = e.data;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (rsp_valid || n >= 20) break;
            check("alu_a", alu_a, m_a);
            check("alu_b", alu_b, m_b);
            check("alu_sel", alu_sel, m_sel);
            check("busy_cmd_ready", cmd_ready, 0);
            n++;
        end
        check("rsp_latency", n, alu_cmd ? LAT + 1 : 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic check_idle_reset();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_rd", rsp_rd, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_sel", alu_sel, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_ld = 1'b0;
        cmd_op = 4'd0;
        cmd_ra = 2'd0;
        cmd_rb = 2'd0;
        cmd_rd = 2'd0;
        cmd_imm = 4'd0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle_reset();

        // Load two registers and add them.
        send(1, 4'd0, 0, 0, 1, 4'b0011);
        send(1, 4'd0, 0, 0, 2, 4'b0101);
        send(0, 4'b1011, 1, 2, 3, 4'd0);
        send(0, 4'd4, 3, 0, 0, 4'd0);

        // Decrement and wrapping add.
        send(1, 4'd0, 0, 0, 1, 4'b1111);
        send(0, 4'b1000, 1, 0, 1, 4'd0);
        send(1, 4'd0, 0, 0, 1, 4'b1111);
        send(1, 4'd0, 0, 0, 2, 4'b0001);
        send(0, 4'b1011, 1, 2, 0, 4'd0);

        // Illegal opcodes, load overriding an illegal opcode, aliasing.
        send(0, 4'b1110, 1, 2, 3, 4'd9);
        send(0, 4'd2, 1, 2, 3, 4'd0);
        send(1, 4'b1111, 0, 0, 2, 4'd6);
        send(0, 4'd9, 2, 2, 2, 4'd0);
        send(0, 4'd10, 0, 2, 1, 4'd0);

        // Stalled response with an ignored command pulse.
        drain();
        hold_ready = 1'b1;
        send(0, 4'd11, 1, 2, 3, 4'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                cmd_ld = 1'b1;
                cmd_rd = 2'd0;
                cmd_imm = 4'd7;
                cmd_valid = 1'b1;
            end
            if (i == 2) cmd_valid = 1'b0;
            check("stall_valid", rsp_valid, 1);
            check("stall_cmd_ready", cmd_ready, 0);
            check("stall_data", rsp_data, exp_q[0].data);
            check("stall_rd", rsp_rd, exp_q[0].rd);
            check("stall_err", rsp_err, exp_q[0].err);
        end
        cmd_valid = 1'b0;
        hold_ready = 1'b0;
        drain();
        send(0, 4'd4, 0, 0, 1, 4'd0);

        // Reset during ISSUE of a write to R2, with a command in the reset cycle.
        send(1, 4'd0, 0, 0, 1, 4'd4);
        send(1, 4'd0, 0, 0, 3, 4'd8);
        drain();
        @(negedge clk);
        cmd_ld = 1'b0;
        cmd_op = 4'd9;
        cmd_ra = 2'd1;
        cmd_rb = 2'd1;
        cmd_rd = 2'd2;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cmd_ld = 1'b1;
        cmd_rd = 2'd3;
        cmd_imm = 4'd5;
        cmd_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cmd_valid = 1'b0;
        model_reset();
        check_idle_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_rsp", rsp_valid, 0);
        end
        send(0, 4'd11, 2, 3, 0, 4'd0);
        send(0, 4'd1, 1, 2, 0, 4'd0);

        // Randomized traffic.
        for (int k = 0; k < 200; k++) begin
            send($urandom_range(0, 3) == 0,
                 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)));
        end
        drain();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter RES_LAT, default 1, meaning the number of cycles the ALU operands are held before alu_res is sampled (legal range 1..7).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1, command present.
REQ-005 SHALL have port cmd_ready, output, 1, sequencer can accept a command.
REQ-006 SHALL have port cmd_op, input, 4, ALU opcode (0000..1100 legal).
REQ-007 SHALL have ports cmd_ra, cmd_rb and cmd_rd, input, 2 each, source A, source B and destination register indices.
REQ-008 SHALL have port cmd_ld, input, 1, load-immediate: write cmd_imm to rd and bypass the ALU.
REQ-009 SHALL have port cmd_imm, input, 4, immediate value.
REQ-010 SHALL have ports alu_a, alu_b and alu_sel, output, 4 each, driven to the 4-bit ALU ports A, B and sel.
REQ-011 SHALL have port alu_res, input, 4, ALU result.
REQ-012 SHALL have port rsp_valid, output, 1, response present.
REQ-013 SHALL have port rsp_ready, input, 1, consumer accepts the response.
REQ-014 SHALL have ports rsp_data (output, 4, value written or computed), rsp_rd (output, 2, destination index) and rsp_err (output, 1, illegal opcode).

Function
REQ-015 SHALL contain four 4-bit registers R0..R3 and FSM states IDLE, ISSUE, CAPTURE, RESP.
REQ-016 SHALL drive cmd_ready=1 only in IDLE; accept occurs on a rising edge with cmd_valid&&cmd_ready.
REQ-017 SHALL on accept latch op, rd, ld, imm and the values R[ra], R[rb] as they are before that edge.
REQ-018 SHALL on accept of a legal ALU command go to ISSUE, drive alu_a=R[ra], alu_b=R[rb], alu_sel=op, and hold them stable for exactly RES_LAT cycles.
REQ-019 SHALL sample alu_res on the last ISSUE edge and enter CAPTURE.
REQ-020 SHALL in CAPTURE write the sampled result to R[rd], load rsp_data/rsp_rd, clear rsp_err, and enter RESP on the next edge; rsp_valid therefore rises RES_LAT+1 cycles after the accept edge.
REQ-021 SHALL on accept with cmd_ld=1 skip ISSUE: CAPTURE writes cmd_imm to R[rd] and leaves alu_* unchanged; cmd_ld overrides cmd_op, including illegal codes.
REQ-022 SHALL on accept with cmd_ld=0 and op in 1101..1111 skip ISSUE: leave every register unchanged, return rsp_data=0000 and rsp_err=1.
REQ-023 SHALL hold rsp_valid=1 and rsp_* stable in RESP until rsp_ready=1 at an edge, then return to IDLE; cmd_ready rises the cycle after response acceptance (no overlap).
REQ-024 SHALL treat all arithmetic as 4-bit modulo 16; the sequencer performs no arithmetic itself.
REQ-025 SHALL hold alu_a/alu_b/alu_sel at their last issued values outside ISSUE.
REQ-026 SHALL make ra=rb=rd legal, with the read value taken before the write.
REQ-027 SHALL ignore cmd_valid outside IDLE; the command is not consumed.

Reset
REQ-028 SHALL when rst=1 at an edge force state IDLE, R0..R3=0000, alu_a=alu_b=alu_sel=0000, rsp_valid=0, rsp_data=0000, rsp_rd=00, rsp_err=0.
REQ-029 SHALL make rst dominate every other input, abort any in-flight command without a register write or response, and ignore a command presented in the reset cycle.

Verification
REQ-030 SHALL be tested with: ld R1=0011, ld R2=0101, then op 1011 ra=1 rb=2 rd=3 -> alu_a=0011, alu_b=0101, alu_sel=1011 for RES_LAT cycles; rsp_data=1000, rsp_rd=11, R3=1000.
REQ-031 SHALL be tested with: R1=1111, op 1000 (A-1) ra=1 rd=1, then op 1011 with R1=1111, R2=0001 -> first rsp_data=1110, then wrap to 0000, with rsp_err=0 both times.
REQ-032 SHALL be tested with: op 1110, cmd_ld=0 -> rsp_err=1, rsp_data=0000, R0..R3 unchanged, alu_* unchanged.
REQ-033 SHALL be tested with: rsp_ready held 0 for 5 cycles -> rsp_valid stays 1, rsp_* stable and cmd_ready=0; a cmd_valid pulse in that window is not consumed.
REQ-034 SHALL be tested with: rst asserted in ISSUE of a write to R2 -> next cycle IDLE, R2=0000, and no rsp_valid.
REQ-035 SHALL be tested with: RES_LAT=3 and the ALU model changing alu_res only after 3 cycles -> correct result captured, and rsp_valid 4 cycles after accept.
